dpram1_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one port (A or B) of the dual-port RAM between NUM_REQ requesters.

---
 rtl/dpram1_port_arbiter.sv | 95 +++++++++
 tb/tb_dpram1_port_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram1_port_arbiter.sv
// dpram1_port_arbiter: round-robin arbiter sharing one RAM port among NUM_REQ requesters, with read-data return routing.
// Define ARB_LOCK_EN to add req_lock, which lets a granted requester keep priority on consecutive cycles.
module dpram1_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int LOG2NREQ = 2,
    parameter int AWIDTH   = 10,
    parameter int DWIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*AWIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DWIDTH-1:0]   req_data,
    input  logic [NUM_REQ*DWIDTH/8-1:0] req_byteen,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]          req_lock,
`endif
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DWIDTH-1:0]           rsp_data,
    output logic [AWIDTH-1:0]           ram_address,
    output logic                        ram_wren,
    output logic [DWIDTH-1:0]           ram_data,
    output logic [DWIDTH/8-1:0]         ram_byteen,
    input  logic [DWIDTH-1:0]           ram_out
);
    localparam int BW = DWIDTH/8;
    logic [LOG2NREQ-1:0] ptr;
    logic [LOG2NREQ-1:0] gnt_id;
    logic [LOG2NREQ-1:0] ptr_inc;
    logic [LOG2NREQ-1:0] ptr_next;
    logic                accept;
    logic                s1_v;
    logic                s2_v;
    logic [LOG2NREQ-1:0] s1_id;
    logic [LOG2NREQ-1:0] s2_id;

    // Scan from the far end so the closest valid bit at/after ptr is written last and wins.
    always_comb begin
        int idx;
        req_ready = '0;
        gnt_id    = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                req_ready      = '0;
                req_ready[idx] = 1'b1;
                gnt_id         = LOG2NREQ'(idx);
            end
        end
    end

    assign accept  = |req_ready;
    assign ptr_inc = (gnt_id == LOG2NREQ'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
`ifdef ARB_LOCK_EN
    assign ptr_next = req_lock[gnt_id] ? gnt_id : ptr_inc;
`else
    assign ptr_next = ptr_inc;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            ram_address <= '0;
            ram_wren    <= 1'b0;
            ram_data    <= '0;
            ram_byteen  <= '0;
            s1_v        <= 1'b0;
            s1_id       <= '0;
            s2_v        <= 1'b0;
            s2_id       <= '0;
        end else begin
            ram_wren <= accept & req_we[gnt_id];
            s1_v     <= accept & ~req_we[gnt_id];
            s1_id    <= gnt_id;
            s2_v     <= s1_v;
            s2_id    <= s1_id;
            if (accept) begin
                ptr         <= ptr_next;
                ram_address <= req_addr[gnt_id*AWIDTH +: AWIDTH];
                ram_data    <= req_data[gnt_id*DWIDTH +: DWIDTH];
                ram_byteen  <= req_byteen[gnt_id*BW +: BW];
            end
        end
    end

    // Second pipe stage lines up with the RAM's registered output.
    always_comb begin
        rsp_valid        = '0;
        rsp_valid[s2_id] = s2_v;
    end

    assign rsp_data = s2_v ? ram_out : '0;
endmodule

// File: tb/tb_dpram1_port_arbiter.sv
// tb_dpram1_port_arbiter: scoreboard bench for dpram1_port_arbiter with a 1-cycle registered RAM model.
// Build with ARB_LOCK_EN defined to also exercise the priority lock.
module tb_dpram1_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW/8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*BW-1:0]   req_byteen;
`ifdef ARB_LOCK_EN
    logic [N-1:0]      req_lock;
`endif
    logic [DW-1:0]     rsp_data, ram_data, ram_out;
    logic [AW-1:0]     ram_address;
    logic              ram_wren;
    logic [BW-1:0]     ram_byteen;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            ref_ptr = 0;
    bit            mon_en = 0;
    rsp_t          sb[$];
    rsp_t          e;
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    dpram1_port_arbiter #(.NUM_REQ(N), .LOG2NREQ(2), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_data(req_data), .req_byteen(req_byteen),
`ifdef ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
        .ram_byteen(ram_byteen), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pattern(int a);
        logic [15:0] lo = a[15:0];
        return {lo ^ 16'h5A5A, lo};
    endfunction

    function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] d, logic [BW-1:0] be);
        logic [DW-1:0] r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int exp_grant(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        logic [N-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Registered-output RAM: read data appears the cycle after the address edge.
    always @(posedge clk) begin
        if (ram_wren === 1'b1) ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_data, ram_byteen);
        ram_out <= ram_mem[ram_address];
    end

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (rsp_valid !== onehot(e.id) || rsp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL rsp cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                             cyc, rsp_valid, rsp_data, onehot(e.id), e.data);
                end
            end else if (rsp_valid !== '0 || rsp_data !== '0) begin
                miscompares++;
                $display("FAIL rsp_idle cyc=%0d: got valid=%b data=%h, want valid=0 data=0",
                         cyc, rsp_valid, rsp_data);
            end
        end
    end

    task automatic model_accept(int g);
        logic [AW-1:0] a = req_addr[g*AW +: AW];
        if (req_we[g]) ref_mem[a] = merge(ref_mem[a], req_data[g*DW +: DW], req_byteen[g*BW +: BW]);
        else sb.push_back('{g, ref_mem[a], cyc + 2});
        ref_ptr = (g + 1) % N;
`ifdef ARB_LOCK_EN
        if (req_lock[g]) ref_ptr = g;
`endif
    endtask

    task automatic clear_req();
        req_valid = '0; req_we = '0; req_addr = '0; req_data = '0; req_byteen = '0;
`ifdef ARB_LOCK_EN
        req_lock = '0;
`endif
    endtask

    task automatic set_req(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [BW-1:0] be);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
        req_byteen[i*BW +: BW] = be;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        ref_ptr = 0;
        clear_req();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain();
        clear_req();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_req();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ram_address, ram_wren, ram_data, ram_byteen, rsp_valid, rsp_data, req_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got addr=%h wren=%b data=%h be=%h rsp=%b/%h ready=%b, want all 0",
                     ram_address, ram_wren, ram_data, ram_byteen, rsp_valid, rsp_data, req_ready);
        end
        mon_en = 1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== '0 || ram_wren !== 1'b0 || rsp_valid !== '0) begin
                miscompares++;
                $display("FAIL idle[%0d]: got ready=%b wren=%b rsp=%b, want 0 0 0", k, req_ready, ram_wren, rsp_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        set_req(1, 1, 10'h005, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL wr_grant: got %b want 0010", req_ready);
        end
        model_accept(1);
        @(posedge clk);
        #1 clear_req();
        set_req(1, 0, 10'h005, 32'h0, 4'h0);
        @(negedge clk);
        vectors++;
        if (ram_wren !== 1'b1 || ram_address !== 10'h005 || ram_data !== 32'hDEADBEEF || ram_byteen !== 4'hF) begin
            miscompares++;
            $display("FAIL wr_cmd: got wren=%b addr=%h data=%h be=%h, want 1 005 deadbeef f",
                     ram_wren, ram_address, ram_data, ram_byteen);
        end
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL rd_grant: got %b want 0010", req_ready);
        end
        model_accept(1);
        @(posedge clk);
        #1 clear_req();
        @(negedge clk);
        vectors++;
        if (ram_wren !== 1'b0 || ram_address !== 10'h005) begin
            miscompares++;
            $display("FAIL rd_cmd: got wren=%b addr=%h, want 0 005", ram_wren, ram_address);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL rd_rsp: got %b/%h want 0010/deadbeef", rsp_valid, rsp_data);
        end
        @(posedge clk);
        #1;
        // Partial write then back-to-back read of the same word.
        set_req(2, 1, 10'h005, 32'h11223344, 4'b0101);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL pwr_grant: got %b want 0100", req_ready);
        end
        model_accept(2);
        @(posedge clk);
        #1 clear_req();
        set_req(2, 0, 10'h005, 32'h0, 4'h0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100 || ref_mem[5] !== 32'hDE22BE44) begin
            miscompares++;
            $display("FAIL praw_grant: got %b/%h want 0100/de22be44", req_ready, ref_mem[5]);
        end
        model_accept(2);
        @(posedge clk);
        #1 drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 0, AW'(i), 32'h0, 4'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== onehot(k % N)) begin
                miscompares++;
                $display("FAIL rr[%0d]: got %b want %b", k, req_ready, onehot(k % N));
            end
            model_accept(k % N);
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_fairness();
        int g;
        int prev = -1;
        bit found = 0;
        set_req(0, 0, 10'h008, 32'h0, 4'h0);
        set_req(2, 0, 10'h009, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g = exp_grant(req_valid, ref_ptr);
            vectors++;
            if (req_ready !== onehot(g) || (g != 0 && g != 2) || g == prev) begin
                miscompares++;
                $display("FAIL alt[%0d]: got %b want %b (prev %0d)", k, req_ready, onehot(g), prev);
            end
            if (g >= 0) model_accept(g);
            prev = g;
            @(posedge clk);
            #1;
        end
        set_req(1, 0, 10'h00A, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            g = exp_grant(req_valid, ref_ptr);
            vectors++;
            if (req_ready !== onehot(g)) begin
                miscompares++;
                $display("FAIL late[%0d]: got %b want %b", k, req_ready, onehot(g));
            end
            if (req_ready[1] === 1'b1) found = 1;
            if (g >= 0) model_accept(g);
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL late_req1: got no grant in 3 cycles, want one");
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        set_req(2, 0, 10'h3FF, 32'h0, 4'h0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL mid_grant: got %b want 0100", req_ready);
        end
        model_accept(2);
        @(posedge clk);
        #1 do_reset();
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) set_req(i, 0, AW'(i + 16), 32'h0, 4'h0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL ptr_after_reset: got %b want 0001", req_ready);
        end
        model_accept(0);
        @(posedge clk);
        #1 drain();
    endtask

    task automatic test_back_to_back();
        int g;
        for (int k = 0; k < 30; k++) begin
            clear_req();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom, BW'($urandom_range(1, 15)));
            @(negedge clk);
            g = exp_grant(req_valid, ref_ptr);
            vectors++;
            if (req_ready !== onehot(g)) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %b want %b", k, req_ready, onehot(g));
            end
            if (g >= 0) model_accept(g);
            @(posedge clk);
            #1;
        end
        drain();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        set_req(2, 0, 10'h001, 32'h0, 4'h0);
        @(negedge clk);
        model_accept(2);
        @(posedge clk);
        #1 clear_req();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                set_req(3, 0, AW'(k + 32), 32'h0, 4'h0);
                req_lock[3] = 1'b1;
            end else begin
                req_valid[3] = 1'b0;
                req_lock[3] = 1'b0;
            end
            set_req(0, 0, 10'h040, 32'h0, 4'h0);
            @(negedge clk);
            vectors++;
            if (req_ready !== (k < 4 ? 4'b1000 : 4'b0001)) begin
                miscompares++;
                $display("FAIL lock[%0d]: got %b want %b", k, req_ready, (k < 4 ? 4'b1000 : 4'b0001));
            end
            model_accept(k < 4 ? 3 : 0);
            @(posedge clk);
            #1;
        end
        drain();
    endtask
`endif

    initial begin
        for (int a = 0; a < (1 << AW); a++) begin
            ram_mem[a] = pattern(a);
            ref_mem[a] = pattern(a);
        end
        test_reset();
        test_write_read();
        test_round_robin();
        test_fairness();
        test_reset_midflight();
        test_back_to_back();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending responses, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
